mux16_serial_scanner: RTL and testbench

- Sequential front-end that drives the 16:1 mux stage (16-bit data word plus 4-bit select) and consumes its 1-bit output.
- Accepts a 16-bit word through a valid/ready load port and presents it to the mux.
- Steps the select 0..15, one step per accepted bit, and streams the mux output as a serial bitstream with valid/ready flow control.
- Turns the combinational 16:1 mux into an LSB-first parallel-to-serial converter.

---
 rtl/mux16_serial_scanner.sv | 111 +++++++++++
 tb/tb_mux16_serial_scanner.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mux16_serial_scanner.sv
// Loads a 16-bit word, steps the external 16:1 mux select 0..15 and streams its output LSB-first.
// Optional PARITY_EN appends an even-parity bit after bit 15.
module mux16_serial_scanner #(
  parameter int DATA_W = 16,
  parameter int SEL_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] mux_in,
  output logic [SEL_W-1:0]  mux_sel,
  input  logic              mux_y,
  output logic              ser_bit,
  output logic              ser_valid,
  input  logic              ser_ready,
  output logic              done
);

  typedef enum logic [1:0] {
    StIdle,
    StSend,
`ifdef PARITY_EN
    StPar,
`endif
    StDone
  } state_e;

  localparam logic [SEL_W-1:0] LastSel = SEL_W'(DATA_W - 1);

  state_e state_q;

`ifdef PARITY_EN
  logic parity_q;
  // The parity bit is sourced internally; the external mux is not consulted in StPar.
  assign ser_bit = (state_q == StPar) ? parity_q : mux_y;
`else
  assign ser_bit = mux_y;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      mux_in     <= '0;
      mux_sel    <= '0;
      load_ready <= 1'b0;
      ser_valid  <= 1'b0;
      done       <= 1'b0;
`ifdef PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (load_valid && load_ready) begin
            mux_in     <= load_data;
            mux_sel    <= '0;
            load_ready <= 1'b0;
            ser_valid  <= 1'b1;
            state_q    <= StSend;
`ifdef PARITY_EN
            parity_q   <= 1'b0;
`endif
          end else begin
            load_ready <= 1'b1;
          end
        end
        StSend: begin
          if (ser_ready) begin
`ifdef PARITY_EN
            parity_q <= parity_q ^ ser_bit;
`endif
            if (mux_sel == LastSel) begin
`ifdef PARITY_EN
              state_q   <= StPar;
`else
              state_q   <= StDone;
              ser_valid <= 1'b0;
              done      <= 1'b1;
`endif
            end else begin
              mux_sel <= mux_sel + 1'b1;
            end
          end
        end
`ifdef PARITY_EN
        StPar: begin
          if (ser_ready) begin
            state_q   <= StDone;
            ser_valid <= 1'b0;
            done      <= 1'b1;
          end
        end
`endif
        StDone: begin
          state_q    <= StIdle;
          mux_sel    <= '0;
          load_ready <= 1'b1;
        end
        default: begin
          state_q    <= StIdle;
          ser_valid  <= 1'b0;
          load_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux16_serial_scanner.sv
// Self-checking bench for mux16_serial_scanner: table-driven frames with a bit scoreboard,
// plus reset and mid-frame-reset sequences. Build with +define+PARITY_EN for the parity variant.
module tb_mux16_serial_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] load_data = 16'h0;
  logic [15:0] mux_in;
  logic [3:0]  mux_sel;
  logic        mux_y;
  logic        ser_bit;
  logic        ser_valid;
  logic        ser_ready = 1'b0;
  logic        done;

`ifdef PARITY_EN
  localparam int NBits = 17;
`else
  localparam int NBits = 16;
`endif

  mux16_serial_scanner #(.DATA_W(16), .SEL_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_data (load_data),
    .mux_in    (mux_in),
    .mux_sel   (mux_sel),
    .mux_y     (mux_y),
    .ser_bit   (ser_bit),
    .ser_valid (ser_valid),
    .ser_ready (ser_ready),
    .done      (done)
  );

  // Behavioural model of the external 16:1 mux.
  assign mux_y = mux_in[mux_sel];

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] word;
    bit          alt;       // ser_ready alternates 1,0 starting at bit 0
    bit          glitch;    // pulse load_valid with 16'hFFFF mid-frame
    logic [15:0] exp_bits;  // expected stream, bit k sent k-th
    bit          exp_par;
    int          exp_done;  // cycle offset of done after the load edge
  } vec_t;

  int  n_chk  = 0;
  int  n_fail = 0;
  bit  exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_frame(input vec_t v);
    int  cyc;
    int  npop;
    int  to;
    bit  seen_done;
    bit  b;
    to = 0;
    while (!load_ready && to < 50) begin
      @(negedge clk);
      to++;
    end
    chk("load_ready_wait", {31'd0, load_ready}, 32'd1);
    load_valid = 1'b1;
    load_data  = v.word;
    ser_ready  = 1'b0;
    for (int k = 0; k < 16; k++) exp_q.push_back(v.exp_bits[k]);
`ifdef PARITY_EN
    exp_q.push_back(v.exp_par);
`endif
    @(negedge clk);
    load_valid = 1'b0;
    load_data  = 16'h0;
    cyc        = 1;
    npop       = 0;
    seen_done  = 1'b0;
    while (!seen_done && cyc < 100) begin
      if (v.glitch && cyc == 3) begin
        load_valid = 1'b1;
        load_data  = 16'hFFFF;
      end else begin
        load_valid = 1'b0;
        load_data  = 16'h0;
      end
      ser_ready = v.alt ? (cyc % 2 == 1) : 1'b1;
      chk("load_ready_busy", {31'd0, load_ready}, 32'd0);
      chk("mux_in_stable", {16'd0, mux_in}, {16'd0, v.word});
      if (done) begin
        chk("done_cycle", cyc, v.exp_done);
        chk("bits_sent", npop, NBits);
        chk("ser_valid_in_done", {31'd0, ser_valid}, 32'd0);
        chk("queue_empty", exp_q.size(), 0);
        seen_done = 1'b1;
      end else begin
        chk("ser_valid", {31'd0, ser_valid}, 32'd1);
        chk("mux_sel", {28'd0, mux_sel}, (npop < 16) ? npop : 15);
        if (ser_ready) begin
          if (exp_q.size() == 0) begin
            chk("extra_bit", 32'd1, 32'd0);
          end else begin
            b = exp_q.pop_front();
            chk("ser_bit", {31'd0, ser_bit}, {31'd0, b});
          end
          npop++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    if (!seen_done) chk("done_timeout", 32'd0, 32'd1);
    load_valid = 1'b0;
    load_data  = 16'h0;
    ser_ready  = 1'b0;
    exp_q.delete();
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("load_ready_back", {31'd0, load_ready}, 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_mux_sel"}, {28'd0, mux_sel}, 32'd0);
    chk({tag, "_mux_in"}, {16'd0, mux_in}, 32'd0);
    chk({tag, "_ser_valid"}, {31'd0, ser_valid}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_load_ready"}, {31'd0, load_ready}, 32'd0);
  endtask

  vec_t vecs[5];
  vec_t v_one;

  initial begin
`ifdef PARITY_EN
    vecs[0] = '{16'hAC69, 1'b0, 1'b0, 16'b1010_1100_0110_1001, 1'b0, 18};
    vecs[1] = '{16'hAC69, 1'b1, 1'b0, 16'b1010_1100_0110_1001, 1'b0, 34};
    vecs[2] = '{16'hAC69, 1'b0, 1'b1, 16'b1010_1100_0110_1001, 1'b0, 18};
    vecs[3] = '{16'h0001, 1'b0, 1'b0, 16'b0000_0000_0000_0001, 1'b1, 18};
    vecs[4] = '{16'h8007, 1'b1, 1'b0, 16'b1000_0000_0000_0111, 1'b0, 34};
    v_one   = '{16'h0001, 1'b0, 1'b0, 16'b0000_0000_0000_0001, 1'b1, 18};
`else
    vecs[0] = '{16'hAC69, 1'b0, 1'b0, 16'b1010_1100_0110_1001, 1'b0, 17};
    vecs[1] = '{16'hAC69, 1'b1, 1'b0, 16'b1010_1100_0110_1001, 1'b0, 32};
    vecs[2] = '{16'hAC69, 1'b0, 1'b1, 16'b1010_1100_0110_1001, 1'b0, 17};
    vecs[3] = '{16'h0001, 1'b0, 1'b0, 16'b0000_0000_0000_0001, 1'b1, 17};
    vecs[4] = '{16'h8007, 1'b1, 1'b0, 16'b1000_0000_0000_0111, 1'b0, 32};
    v_one   = '{16'h0001, 1'b0, 1'b0, 16'b0000_0000_0000_0001, 1'b1, 17};
`endif

    // Reset held for 3 cycles.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("load_ready_after_release", {31'd0, load_ready}, 32'd1);

    for (int i = 0; i < 5; i++) run_frame(vecs[i]);

    // Mid-frame reset after the 5th bit has transferred.
    begin
      int npop;
      int to;
      load_valid = 1'b1;
      load_data  = 16'hAC69;
      @(negedge clk);
      load_valid = 1'b0;
      ser_ready  = 1'b1;
      npop = 0;
      to   = 0;
      while (npop < 5 && to < 40) begin
        if (ser_valid) npop++;
        @(negedge clk);
        to++;
      end
      chk("midreset_progress", npop, 5);
      chk("midreset_sel_before", {28'd0, mux_sel}, 32'd5);
      rst = 1'b1;
      #1;
      chk_reset_vals("midreset");
      ser_ready = 1'b0;
      repeat (2) begin
        @(negedge clk);
        chk("midreset_no_done", {31'd0, done}, 32'd0);
      end
      rst = 1'b0;
      @(negedge clk);
      chk("midreset_no_done_after", {31'd0, done}, 32'd0);
      chk("midreset_load_ready", {31'd0, load_ready}, 32'd1);
    end
    run_frame(v_one);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
